// File: rtl/decode_issue_pkg.sv
// Shared decode definitions: opcode map, default widths, funct packing.
// Imported by the decode stage and the ALU.
package decode_issue_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    function automatic logic [3:0] pack_funct(input logic [31:0] instr);
        return {instr[30], instr[14:12]};
    endfunction

endpackage

// File: rtl/decode_issue_imm_gen.sv
// Immediate generator: one sign-extended immediate per instruction format.
// Purely combinational.
module imm_gen #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] imm_s,
    output logic [XLEN-1:0] imm_b,
    output logic [XLEN-1:0] imm_u,
    output logic [XLEN-1:0] imm_j
);

    assign imm_i = XLEN'($signed(instr[31:20]));
    assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign imm_b = XLEN'($signed({instr[31], instr[7],
                                  instr[30:25], instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({instr[31], instr[19:12],
                                  instr[20], instr[30:21], 1'b0}));

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: reads operands, builds the registered ALU bundle.
// Define DECODE_SCOREBOARD_EN to stall on read-after-write hazards.
module decode_issue
    import decode_issue_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rs1,
    output logic [XLEN-1:0] out_rs2,
    output logic [6:0]      out_opcode,
    output logic [3:0]      out_funct,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_store_data,
    output logic            out_illegal,
    input  logic            flush,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd
);

    logic [6:0]      op;
    logic [4:0]      rda;
    logic [XLEN-1:0] rd1, rd2;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] d_rs1, d_rs2, d_imm, d_sd;
    logic [4:0]      d_rd;
    logic            d_ill, use1, use2;
    logic            stall, accept;

    assign op        = in_instr[6:0];
    assign rda       = in_instr[11:7];
    assign rf_raddr1 = in_instr[19:15];
    assign rf_raddr2 = in_instr[24:20];

    assign rd1 = (rf_raddr1 == 5'd0) ? '0 : rf_rdata1;
    assign rd2 = (rf_raddr2 == 5'd0) ? '0 : rf_rdata2;

    imm_gen #(.XLEN(XLEN)) u_imm (
        .instr (in_instr),
        .imm_i (imm_i),
        .imm_s (imm_s),
        .imm_b (imm_b),
        .imm_u (imm_u),
        .imm_j (imm_j)
    );

    always_comb begin
        d_rs1 = '0;
        d_rs2 = '0;
        d_imm = '0;
        d_sd  = '0;
        d_rd  = '0;
        d_ill = 1'b0;
        use1  = 1'b0;
        use2  = 1'b0;
        unique case (1'b1)
            (op == OP_R): begin
                d_rs1 = rd1;
                d_rs2 = rd2;
                d_rd  = rda;
                use1  = 1'b1;
                use2  = 1'b1;
            end
            (op == OP_I), (op == OP_LOAD), (op == OP_JALR): begin
                d_rs1 = rd1;
                d_rs2 = imm_i;
                d_imm = imm_i;
                d_rd  = rda;
                use1  = 1'b1;
            end
            (op == OP_STORE): begin
                d_rs1 = rd1;
                d_rs2 = imm_s;
                d_imm = imm_s;
                d_sd  = rd2;
                use1  = 1'b1;
                use2  = 1'b1;
            end
            (op == OP_BRANCH): begin
                d_rs1 = rd1;
                d_rs2 = rd2;
                d_imm = imm_b;
                use1  = 1'b1;
                use2  = 1'b1;
            end
            (op == OP_LUI), (op == OP_AUIPC): begin
                d_rs2 = imm_u;
                d_imm = imm_u;
                d_rd  = rda;
            end
            (op == OP_JAL): begin
                d_rs2 = imm_j;
                d_imm = imm_j;
                d_rd  = rda;
            end
            default: d_ill = 1'b1;
        endcase
    end

`ifdef DECODE_SCOREBOARD_EN
    // Bit 0 exists only so any 5-bit index is legal; it is never set.
    logic [NREGS-1:0] busy;
    logic             hz1, hz2;

    assign hz1 = use1 && (rf_raddr1 != 5'd0) &&
                 (busy[rf_raddr1] || (out_valid && out_rd == rf_raddr1));
    assign hz2 = use2 && (rf_raddr2 != 5'd0) &&
                 (busy[rf_raddr2] || (out_valid && out_rd == rf_raddr2));
    assign stall = hz1 || hz2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            if (wb_valid)
                busy[wb_rd] <= 1'b0;
            if (out_valid && out_ready && out_rd != 5'd0)
                busy[out_rd] <= 1'b1;
            busy[0] <= 1'b0;
        end
    end
`else
    logic unused_sb;
    assign unused_sb = ^{wb_valid, wb_rd, use1, use2};
    assign stall     = 1'b0;
`endif

    assign in_ready = (!out_valid || out_ready) && !flush && !stall;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid      <= 1'b0;
            out_rs1        <= '0;
            out_rs2        <= '0;
            out_opcode     <= '0;
            out_funct      <= '0;
            out_pc         <= '0;
            out_rd         <= '0;
            out_imm        <= '0;
            out_store_data <= '0;
            out_illegal    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_rs1        <= d_rs1;
            out_rs2        <= d_rs2;
            out_opcode     <= op;
            out_funct      <= pack_funct(in_instr);
            out_pc         <= in_pc;
            out_rd         <= d_rd;
            out_imm        <= d_imm;
            out_store_data <= d_sd;
            out_illegal    <= d_ill;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
// Scoreboard bench for decode_issue: directed cases then random traffic.
// Honours DECODE_SCOREBOARD_EN the same way the design does.
`timescale 1ns/1ps
module tb_decode_issue;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_rs1, out_rs2, out_pc, out_imm, out_store_data;
    logic [6:0]  out_opcode;
    logic [3:0]  out_funct;
    logic [4:0]  out_rd;
    logic        out_illegal;
    logic        flush = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;

    decode_issue dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instr       (in_instr),
        .in_pc          (in_pc),
        .rf_raddr1      (rf_raddr1),
        .rf_raddr2      (rf_raddr2),
        .rf_rdata1      (rf_rdata1),
        .rf_rdata2      (rf_rdata2),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_rs1        (out_rs1),
        .out_rs2        (out_rs2),
        .out_opcode     (out_opcode),
        .out_funct      (out_funct),
        .out_pc         (out_pc),
        .out_rd         (out_rd),
        .out_imm        (out_imm),
        .out_store_data (out_store_data),
        .out_illegal    (out_illegal),
        .flush          (flush),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd)
    );

    always #5 clock = ~clock;

    logic [31:0] rf [32];
    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    typedef struct {
        logic [31:0] rs1, rs2, imm, sd, pc;
        logic [6:0]  op;
        logic [3:0]  funct;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t q[$];
    bit   busy_m [32];
    int   checks = 0;
    int   failures = 0;

    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                             7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] rdreg(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : rf[a];
    endfunction

    // Reference decode computed from the field layouts with integer maths.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p);
        exp_t e;
        int   iv, sv, bv, jv;
        logic [31:0] a, b, uv;
        a  = rdreg(ins[19:15]);
        b  = rdreg(ins[24:20]);
        iv = int'(ins[31:20]);
        if (ins[31]) iv -= 4096;
        sv = int'(ins[31:25]) * 32 + int'(ins[11:7]);
        if (ins[31]) sv -= 4096;
        bv = int'(ins[31]) * 4096 + int'(ins[7]) * 2048
           + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        if (ins[31]) bv -= 8192;
        jv = int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * 4096
           + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        if (ins[31]) jv -= (1 << 21);
        uv = ins & 32'hFFFFF000;
        e.op = ins[6:0];
        e.funct = {ins[30], ins[14:12]};
        e.pc = p;
        e.rs1 = 0; e.rs2 = 0; e.imm = 0; e.sd = 0; e.rd = 0; e.ill = 0;
        case (ins[6:0])
            7'h33: begin e.rs1 = a; e.rs2 = b; e.rd = ins[11:7]; end
            7'h13, 7'h03, 7'h67: begin
                e.rs1 = a; e.rs2 = iv; e.imm = iv; e.rd = ins[11:7];
            end
            7'h23: begin e.rs1 = a; e.rs2 = sv; e.imm = sv; e.sd = b; end
            7'h63: begin e.rs1 = a; e.rs2 = b; e.imm = bv; end
            7'h37, 7'h17: begin e.rs2 = uv; e.imm = uv; e.rd = ins[11:7]; end
            7'h6F: begin e.rs2 = jv; e.imm = jv; e.rd = ins[11:7]; end
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    function automatic bit model_stall(input logic [31:0] ins, input bit held,
                                       input logic [4:0] hrd);
`ifdef DECODE_SCOREBOARD_EN
        logic [6:0] o;
        logic [4:0] r1, r2;
        bit u1, u2, h1, h2;
        o  = ins[6:0];
        r1 = ins[19:15];
        r2 = ins[24:20];
        u1 = o inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63};
        u2 = o inside {7'h33, 7'h23, 7'h63};
        h1 = u1 && r1 != 0 && (busy_m[r1] || (held && hrd == r1));
        h2 = u2 && r2 != 0 && (busy_m[r2] || (held && hrd == r2));
        return h1 || h2;
`else
        return 1'b0 & held & (ins != hrd);
`endif
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins,
                         input logic [31:0] p, input logic ordy,
                         input logic fl, input logic wbv,
                         input logic [4:0] wr, output bit acc);
        bit         held, rdy;
        logic [4:0] hrd;
        @(negedge clock);
        in_valid = v; in_instr = ins; in_pc = p; out_ready = ordy;
        flush = fl; wb_valid = wbv; wb_rd = wr;
        #1;
        held = (q.size() != 0);
        hrd  = held ? q[0].rd : 5'd0;
        rdy  = (!held || ordy) && !fl && !model_stall(ins, held, hrd);
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("rf_raddr1", 32'(rf_raddr1), 32'(ins[19:15]));
        chk("rf_raddr2", 32'(rf_raddr2), 32'(ins[24:20]));
        if (fl && held) void'(q.pop_front());
        acc = v && rdy;
        if (acc) q.push_back(model(ins, p));
        if (wbv) busy_m[wr] = 0;
        if (held && ordy && !fl && hrd != 0) busy_m[hrd] = 1;
        busy_m[0] = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_rs1"}, out_rs1, 0);
        chk({tag, "_rs2"}, out_rs2, 0);
        chk({tag, "_pc"}, out_pc, 0);
        chk({tag, "_rd"}, 32'(out_rd), 0);
        chk({tag, "_imm"}, out_imm, 0);
    endtask

    // Monitor: bundle presence and content against the expectation queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset_n)
                chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            #2;
            if (reset_n && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_bundle actual=pc %h required=none", out_pc);
                end else begin
                    e = q.pop_front();
                    chk("rs1", out_rs1, e.rs1);
                    chk("rs2", out_rs2, e.rs2);
                    chk("opcode", 32'(out_opcode), 32'(e.op));
                    chk("funct", 32'(out_funct), 32'(e.funct));
                    chk("pc", out_pc, e.pc);
                    chk("rd", 32'(out_rd), 32'(e.rd));
                    chk("imm", out_imm, e.imm);
                    chk("store_data", out_store_data, e.sd);
                    chk("illegal", 32'(out_illegal), 32'(e.ill));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    localparam logic [31:0] ADD3  = {7'd0, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33};
    localparam logic [31:0] ADDI4 = 32'hFFF08213;
    localparam logic [31:0] SRAI5 = {7'b0100000, 5'd3, 5'd1, 3'b101, 5'd5, 7'h13};
    localparam logic [31:0] SW    = {7'd0, 5'd2, 5'd1, 3'b010, 5'd8, 7'h23};
    localparam logic [31:0] ILL   = 32'h0000007F;
    localparam logic [31:0] LUI   = {20'hABCDE, 5'd9, 7'h37};
    localparam logic [31:0] AUIPC = {20'h12345, 5'd10, 7'h17};
    localparam logic [31:0] LW6   = {12'd0, 5'd1, 3'b010, 5'd6, 7'h03};
    localparam logic [31:0] ADD7  = {7'd0, 5'd1, 5'd6, 3'd0, 5'd7, 7'h33};
    localparam logic [31:0] ADDI0 = {12'd1, 5'd1, 3'd0, 5'd0, 7'h13};
    localparam logic [31:0] ADD8  = {7'd0, 5'd0, 5'd0, 3'd0, 5'd8, 7'h33};

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom();
        r[6:0]   = ops[$urandom_range(0, 9)];
        r[11:7]  = 5'($urandom_range(0, 7));
        r[19:15] = 5'($urandom_range(0, 7));
        r[24:20] = 5'($urandom_range(0, 7));
        return r;
    endfunction

    initial begin
        bit          acc, pend, fl, ordy;
        logic [31:0] pins, ppc;
        for (int i = 0; i < 32; i++) begin
            rf[i] = $urandom();
            busy_m[i] = 0;
        end
        rf[0] = 32'hDEADBEEF;
        rf[1] = 32'd5;
        rf[2] = 32'd7;

        @(negedge clock);
        #1;
        check_zero("reset");
        @(posedge clock);
        #1 reset_n = 1'b1;

        drive(1, ADD3, 32'h100, 0, 0, 0, 0, acc);
        drive(1, ADDI4, 32'h104, 0, 0, 0, 0, acc);
        chk("add_valid", 32'(out_valid), 1);
        chk("add_rs1", out_rs1, 5);
        chk("add_rs2", out_rs2, 7);
        chk("add_rd", 32'(out_rd), 3);
        chk("add_funct", 32'(out_funct), 0);
        chk("add_opcode", 32'(out_opcode), 32'h33);
        for (int k = 0; k < 2; k++) begin
            drive(1, ADDI4, 32'h104, 0, 0, 0, 0, acc);
            chk("hold_rs2", out_rs2, 7);
        end
        drive(1, ADDI4, 32'h104, 1, 0, 0, 0, acc);
        drive(1, SRAI5, 32'h108, 1, 0, 0, 0, acc);
        chk("addi_rs2", out_rs2, 32'hFFFFFFFF);
        chk("addi_rd", 32'(out_rd), 4);
        drive(1, SW, 32'h10C, 1, 0, 0, 0, acc);
        chk("srai_rs2", out_rs2, 32'h403);
        drive(1, ILL, 32'h110, 1, 0, 0, 0, acc);
        chk("sw_rs2", out_rs2, 8);
        chk("sw_store", out_store_data, 7);
        chk("sw_rd", 32'(out_rd), 0);
        drive(1, LUI, 32'h114, 1, 0, 0, 0, acc);
        chk("ill_flag", 32'(out_illegal), 1);
        chk("ill_rd", 32'(out_rd), 0);
        drive(1, AUIPC, 32'h118, 0, 1, 0, 0, acc);
        drive(0, AUIPC, 32'h118, 0, 0, 0, 0, acc);
        chk("flush_valid", 32'(out_valid), 0);

        drive(1, LW6, 32'h200, 1, 0, 0, 0, acc);
        for (int k = 0; k < 3; k++)
            drive(1, ADD7, 32'h204, 1, 0, 0, 0, acc);
        drive(1, ADD7, 32'h204, 1, 0, 1, 5'd6, acc);
`ifdef DECODE_SCOREBOARD_EN
        chk("wb_no_bypass", 32'(in_ready), 0);
`endif
        drive(1, ADD7, 32'h204, 1, 0, 0, 0, acc);
        chk("after_wb_ready", 32'(in_ready), 1);
        drive(1, ADDI0, 32'h208, 1, 0, 0, 0, acc);
        drive(1, ADD8, 32'h20C, 1, 0, 0, 0, acc);
        chk("x0_no_stall", 32'(in_ready), 1);

        pend = 0;
        pins = '0;
        ppc  = '0;
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) begin
                @(posedge clock);
                #1 reset_n = 1'b0;
                #1;
                check_zero("midreset");
                q.delete();
                foreach (busy_m[j]) busy_m[j] = 0;
                in_valid = 0; flush = 0; out_ready = 0; wb_valid = 0;
                pend = 0;
                @(posedge clock);
                #1 reset_n = 1'b1;
            end
            if (!pend) begin
                pins = rand_instr();
                ppc  = $urandom() & 32'hFFFFFFFC;
                pend = ($urandom_range(0, 2) != 0);
            end
            fl   = ($urandom_range(0, 19) == 0);
            ordy = !fl && ($urandom_range(0, 3) != 0);
            drive(pend, pins, ppc, ordy, fl, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), acc);
            if (acc || fl) pend = 0;
        end

        for (int i = 0; i < 20; i++)
            drive(0, 32'h0, 32'h0, 1, 0, 1, 5'(i % 8), acc);
        @(negedge clock);
        #3;
        chk("drained", 32'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- Decode stage feeding the ALU. Accepts a 32-bit instruction and its PC from fetch over a valid/ready handshake.
- Reads the register file and generates the immediate, then presents a registered operand bundle to the ALU: rs1, rs2, opcode, funct, pc.
- Holds the bundle until execute accepts it, and supports flush on a taken branch or jump.
- Optionally stalls on read-after-write hazards using a register scoreboard.

Parameters:
- XLEN, 32, datapath and operand width.
- NREGS, 32, architectural register count; x0 is hardwired zero.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch has an instruction.
- in_ready  out  1  decode accepts this cycle.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  instruction address.
- rf_raddr1  out  5  equals in_instr[19:15], combinational.
- rf_raddr2  out  5  equals in_instr[24:20], combinational.
- rf_rdata1  in  XLEN  register file read data, same cycle as address.
- rf_rdata2  in  XLEN  register file read data, same cycle as address.
- out_valid  out  1  bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_rs1  out  XLEN  ALU operand A.
- out_rs2  out  XLEN  ALU operand B (register value or immediate).
- out_opcode  out  7  instr[6:0].
- out_funct  out  4  {instr[30], instr[14:12]}.
- out_pc  out  XLEN  PC of the bundle.
- out_rd  out  5  destination register; 0 if the instruction does not write.
- out_imm  out  XLEN  sign-extended immediate, used for branch/jump targets.
- out_store_data  out  XLEN  rf_rdata2 for stores, else 0.
- out_illegal  out  1  unrecognised opcode.
- flush  in  1  discard the held bundle and the current input.
- wb_valid  in  1  writeback completing.
- wb_rd  in  5  register being written back.

Behaviour:
- Reset (async assert, sync release): out_valid=0; all out_* data=0; scoreboard cleared.
- Latency: 1 cycle. An instruction accepted at edge N is out_valid after edge N.
- Handshake:
  - in_ready = (!out_valid || out_ready) && !flush && !stall.
  - Accept = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
  - Bundle holds stable while out_valid && !out_ready.
  - in_ready never depends combinationally on in_valid.
- Flush has priority over everything. The next cycle has out_valid=0, and the input is not accepted that cycle.
- Operand formation by opcode:
  - 0110011 (R): rs1=rdata1, rs2=rdata2.
  - 0010011, 0000011, 1100111 (I, load, jalr): rs1=rdata1, rs2=sext(instr[31:20]). Shift variants therefore carry instr[31:25] in rs2[11:5].
  - 0100011 (S): rs1=rdata1, rs2=sext({instr[31:25], instr[11:7]}), store_data=rdata2.
  - 1100011 (B): rs1=rdata1, rs2=rdata2, imm=sext B-imm with bit0=0.
  - 0110111, 0010111 (lui, auipc): rs1=0, rs2={instr[31:12], 12'b0}.
  - 1101111 (jal): rs1=0, rs2=imm=sext J-imm.
  - Any other opcode: out_illegal=1, rs1=rs2=rd=0, opcode still passed through.
- out_rd = instr[11:7] for R, I, load, jalr, jal, lui and auipc; otherwise 0. A nonzero out_rd means the instruction writes a register.
- Register reads of x0 are forced to 0 regardless of rf_rdata.

Optional Feature:
- Macro DECODE_SCOREBOARD_EN.
- Defined:
  - busy[NREGS-1:1] bits, with x0 never busy.
  - Set busy[out_rd] on an output transfer with out_rd != 0.
  - Clear busy[wb_rd] when wb_valid is high.
  - Set and clear of the same register in the same cycle: set wins.
  - stall = the instruction uses rs1 (or rs2) and that register is busy, or it equals out_rd of a held valid bundle with out_rd != 0.
  - A writeback clearing a register this cycle does not unstall until the next cycle (no bypass).
  - flush does not alter busy.
- Undefined: stall=0 and no busy state. Hazards are resolved by software scheduling.

Decomposition:
- Shared package holds: the opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC), the XLEN default, and the funct packing {instr[30], funct3}. The ALU and this block both import it.
- One sub-module, imm_gen: combinational instr to sign-extended immediate, one output per format.

Test Plan:
- add x3,x1,x2 with rf x1=5, x2=7 → next cycle: out_valid=1, opcode=0110011, funct=0000, rs1=5, rs2=7, rd=3.
- addi x4,x1,-1 (instr 0xFFF08213) → rs2=0xFFFFFFFF, funct[2:0]=000, rd=4. srai x5,x1,3 → rs2[11:5]=0100000, rs2[4:0]=3.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and the bundle is unchanged. Raise out_ready → next instruction appears one cycle later, with no loss or duplication.
- flush asserted while a bundle is held and in_valid=1 → out_valid=0 the next cycle and the input is not consumed. Reset_n pulsed mid-stream → all outputs 0 immediately.
- With DECODE_SCOREBOARD_EN: lw x6 issued, then add x7,x6,x1 → in_ready=0 until the cycle after wb_valid=1 with wb_rd=6. An instruction writing x0 never stalls a later reader.
- Opcode 0x7F → out_illegal=1, rd=0. A sw x2,8(x1) → rs2=8, store_data=rf x2, rd=0.
